mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter VEC_S, default 3, is the vector length and matrix dimension; only the value 3 is supported.
REQ-002 clk  input  1  sole clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 s_data  input  8  load word; signed, except bias words, which are unsigned.
REQ-005 s_valid  input  1  load word valid.
REQ-006 s_ready  output  1  feeder accepts a load word; a transfer occurs when s_valid and s_ready are both 1 at a posedge.
REQ-007 mac_a / mac_b  output  8 each  signed operands to the MAC.
REQ-008 mac_x  output  8  unsigned bias to the MAC.
REQ-009 mac_valid  output  1  operand-valid strobe to the MAC.
REQ-010 mac_f  input  16  signed MAC row result.
REQ-011 mac_valid_out  input  1  MAC result strobe.
REQ-012 mac_overflow  input  1  MAC per-step overflow pulse.
REQ-013 m_data  output  16  signed result word.
REQ-014 m_ovf  output  1  overflow flag for the row in m_data.
REQ-015 m_valid / m_ready  output / input  1 each  result handshake.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky flag for a stray mac_valid_out.

Function
REQ-018 FSM states: IDLE, LOAD, STREAM, WAIT, OUT.
REQ-019 IDLE -> LOAD on the first s_valid.
- A word is accepted in the same cycle as this transition.
REQ-020 LOAD accepts exactly 15 words in this order:
- W[0][0..2], W[1][0..2], W[2][0..2] (row-major);
- then V[0..2];
- then bias[0..2].
REQ-021 s_ready is 1 only in IDLE and LOAD; gaps in s_valid stall loading with no loss of words.
REQ-022 LOAD -> STREAM on the cycle after the 15th word is accepted.
REQ-023 STREAM drives mac_valid=1 for exactly 9 consecutive cycles, in order r=0..2, c=0..2:
- mac_a=W[r][c], mac_b=V[c], mac_x=bias[r];
- all MAC outputs are registered.
REQ-024 Outside STREAM, mac_valid=0 and mac_a, mac_b, mac_x hold their last values.
REQ-025 STREAM -> WAIT after the 9th strobe.
REQ-026 In WAIT, each mac_valid_out stores mac_f into result buffer entry k (k=0..2, incrementing).
REQ-027 Per-row overflow capture:
- each row's ovf bit is the OR of mac_overflow over the cycles from the previous capture (exclusive) to this capture (inclusive);
- the accumulator clears after each capture.
REQ-028 WAIT -> OUT after the 3rd capture; the MAC latency is not counted, only the returns.
REQ-029 OUT presents entries 0, 1, 2 in order on m_data / m_ovf with m_valid=1.
- An entry advances only on m_valid & m_ready.
- While m_ready=0, m_data, m_ovf and m_valid hold stable.
REQ-030 After the 3rd handshake: m_valid=0 next cycle, FSM -> IDLE, and a new load may begin immediately.
REQ-031 A mac_valid_out in any state other than WAIT is ignored for data and sets err=1; err clears only on reset.
REQ-032 s_valid outside IDLE/LOAD has no effect.

Reset
REQ-033 reset=0 immediately forces:
- state=IDLE; all counters 0;
- s_ready=0 while reset is asserted, then 1 in IDLE;
- mac_valid=0; mac_a=mac_b=mac_x=0;
- m_valid=0, m_data=0, m_ovf=0, err=0, busy=0.
REQ-034 Reset mid-operation discards loaded operands and buffered results; the first cycle after release is IDLE.
- MAC-side state is reset by its own reset.

Structure
REQ-035 A shared package holds:
- VEC_S;
- the FSM state enum;
- the load word count 15;
- the operand and result widths, 8 and 16.
REQ-036 Result buffering is a sub-module, mac_result_buf: 3 entries x 17 bits, write port from WAIT, read port with the valid/ready handshake.

Verification
REQ-037 Bench connects mac_feeder to the MAC (6-stage multiplier config) and a scoreboard.
- Scenario 1: W=identity, V=(1,2,3), bias=(0,0,0) -> m_data 1, 2, 3; m_ovf=0 each.
REQ-038 Scenario 2: W all 2, V all 3, bias=(5,0,10) -> m_data 23, 18, 28.
REQ-039 Scenario 3: W all 127, V all 127, bias 0 -> each row sums to 48387 > 32767, so m_ovf=1 on all 3 results.
REQ-040 Scenario 4: random s_valid gaps during load and m_ready=0 for 5 cycles at each result -> same data as with no stalls, and m_data is stable while stalled.
REQ-041 Scenario 5: reset asserted on the 4th STREAM cycle -> outputs take their reset values at once; a following clean load of scenario 1 yields 1, 2, 3.
REQ-042 Scenario 6: force mac_valid_out=1 while in IDLE -> err=1 and sticky; the following normal run produces correct data.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
`default_nettype none
// mac_feeder_pkg: shared sizes, FSM state type and operand indexing for the MAC feeder.
package mac_feeder_pkg;

    localparam int VEC_S      = 3;
    localparam int LOAD_WORDS = VEC_S * VEC_S + 2 * VEC_S;
    localparam int OP_W       = 8;
    localparam int RES_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Position of W[row][col] in the row-major load sequence.
    function automatic logic [3:0] w_index(input logic [1:0] row, input logic [1:0] col);
        return 4'(row) * 4'(VEC_S) + 4'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_result_buf.sv
`default_nettype none
// mac_result_buf: three-entry row-result store, written from WAIT and drained
// through a valid/ready port in OUT.
module mac_result_buf
    import mac_feeder_pkg::*;
#(
    parameter int DEPTH = VEC_S
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [RES_W:0]   wr_data_i,
    input  logic             rd_en_i,
    input  logic             m_ready_i,
    output logic [RES_W-1:0] m_data_o,
    output logic             m_ovf_o,
    output logic             m_valid_o,
    output logic             last_wr_o,
    output logic             last_rd_o
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    logic [RES_W:0] mem_q [DEPTH];
    logic [1:0]     wr_ptr_q;
    logic [1:0]     rd_ptr_q;
    logic           handshake;

    assign handshake = rd_en_i & m_ready_i;
    assign last_wr_o = wr_en_i && (wr_ptr_q == LAST);
    assign last_rd_o = handshake && (rd_ptr_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= last_wr_o ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (handshake) begin
                rd_ptr_q <= last_rd_o ? 2'd0 : rd_ptr_q + 2'd1;
            end
        end
    end

    // Output is zero outside OUT so the port reads clean after reset.
    assign m_valid_o             = rd_en_i;
    assign {m_ovf_o, m_data_o}   = rd_en_i ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/mac_feeder.sv
`default_nettype none
// mac_feeder: loads a 3x3 matrix, vector and bias, streams the nine products'
// operands to an external MAC and returns the three row results with overflow.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int VEC_S = mac_feeder_pkg::VEC_S
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic [OP_W-1:0]  mac_x,
    output logic             mac_valid,
    input  logic [RES_W-1:0] mac_f,
    input  logic             mac_valid_out,
    input  logic             mac_overflow,
    output logic [RES_W-1:0] m_data,
    output logic             m_ovf,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] LAST_IDX  = 2'(VEC_S - 1);
    localparam logic [3:0] LAST_WORD = 4'(LOAD_WORDS - 1);
    localparam logic [3:0] V_BASE    = 4'(VEC_S * VEC_S);
    localparam logic [3:0] B_BASE    = 4'(VEC_S * VEC_S + VEC_S);

    state_t          state_q, state_d;
    logic [3:0]      ld_cnt_q, ld_cnt_d;
    logic [1:0]      row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [OP_W-1:0] word_q [LOAD_WORDS];
    logic            mac_valid_q, mac_valid_d;
    logic [OP_W-1:0] mac_a_q, mac_a_d;
    logic [OP_W-1:0] mac_b_q, mac_b_d;
    logic [OP_W-1:0] mac_x_q, mac_x_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic            err_q, err_d;
    logic            accept;
    logic            capture;
    logic            rd_en;
    logic            last_wr;
    logic            last_rd;

    // Gated by reset so the source sees no ready while reset is held.
    assign s_ready = reset && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign accept  = s_valid && s_ready;
    assign capture = (state_q == ST_WAIT) && mac_valid_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ld_cnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_x_q     <= '0;
            ovf_acc_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mac_valid_q <= mac_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_x_q     <= mac_x_d;
            ovf_acc_q   <= ovf_acc_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = 4'd1;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    if (ld_cnt_q == LAST_WORD) begin
                        state_d  = ST_STREAM;
                        ld_cnt_d = '0;
                        row_d    = '0;
                        col_d    = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 4'd1;
                    end
                end
            end
            ST_STREAM: begin
                if (col_q == LAST_IDX) begin
                    col_d = '0;
                    if (row_q == LAST_IDX) begin
                        row_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (last_wr) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (last_rd) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MAC operands are registered from the next-state view, so each strobe
    // lines up with the STREAM cycle that owns its (row, col).
    always_comb begin
        mac_valid_d = (state_d == ST_STREAM);
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_x_d     = mac_x_q;
        if (state_d == ST_STREAM) begin
            mac_a_d = word_q[w_index(row_d, col_d)];
            mac_b_d = word_q[V_BASE + 4'(col_d)];
            mac_x_d = word_q[B_BASE + 4'(row_d)];
        end
        ovf_acc_d = capture ? 1'b0 : (ovf_acc_q | mac_overflow);
        err_d     = err_q | (mac_valid_out && (state_q != ST_WAIT));
        busy      = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LOAD_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (accept) begin
            word_q[ld_cnt_q] <= s_data;
        end
    end

    assign mac_valid = mac_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_x     = mac_x_q;
    assign err       = err_q;

    mac_result_buf #(
        .DEPTH (VEC_S)
    ) u_result_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (capture),
        .wr_data_i ({ovf_acc_q | mac_overflow, mac_f}),
        .rd_en_i   (rd_en),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_ovf_o   (m_ovf),
        .m_valid_o (m_valid),
        .last_wr_o (last_wr),
        .last_rd_o (last_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// tb_mac_feeder: feeder driven against a behavioural 6-stage MAC, results
// compared with row sums computed directly from the loaded words.
module tb_mac_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  mac_a, mac_b, mac_x;
    logic        mac_valid;
    logic [15:0] mac_f;
    logic        mac_valid_out;
    logic        mac_overflow;
    logic [15:0] m_data;
    logic        m_ovf;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        err;

    logic        force_vo = 1'b0;
    logic        mdl_vo;
    logic        mdl_ovf;
    logic [15:0] mdl_f;

    logic [7:0]  words [15];
    logic [15:0] exp_d [3];
    logic        exp_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_feeder #(.VEC_S(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_x         (mac_x),
        .mac_valid     (mac_valid),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .mac_overflow  (mac_overflow),
        .m_data        (m_data),
        .m_ovf         (m_ovf),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .err           (err)
    );

    // Behavioural MAC: six pipeline stages, accumulates three products per
    // row, adds the unsigned bias on the last one and flags any partial sum
    // that leaves the signed 16-bit range.
    logic       p_v [6];
    int         p_p [6];
    logic [7:0] p_x [6];
    int         acc;
    int         step;
    int         w_part;
    int         w_sum;
    logic       w_ovf;

    function automatic bit oor(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    always_comb begin
        w_part = acc + p_p[5];
        w_sum  = w_part + ((step == 2) ? int'(p_x[5]) : 0);
        w_ovf  = oor(w_part) || oor(w_sum);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                p_v[i] <= 1'b0;
                p_p[i] <= 0;
                p_x[i] <= 8'd0;
            end
            acc     <= 0;
            step    <= 0;
            mdl_vo  <= 1'b0;
            mdl_ovf <= 1'b0;
            mdl_f   <= 16'd0;
        end else begin
            p_v[0] <= mac_valid;
            p_p[0] <= int'($signed(mac_a)) * int'($signed(mac_b));
            p_x[0] <= mac_x;
            for (int i = 1; i < 6; i++) begin
                p_v[i] <= p_v[i-1];
                p_p[i] <= p_p[i-1];
                p_x[i] <= p_x[i-1];
            end
            mdl_vo  <= 1'b0;
            mdl_ovf <= 1'b0;
            if (p_v[5]) begin
                mdl_ovf <= w_ovf;
                if (step == 2) begin
                    mdl_vo <= 1'b1;
                    mdl_f  <= w_sum[15:0];
                    acc    <= 0;
                    step   <= 0;
                end else begin
                    acc  <= w_part;
                    step <= step + 1;
                end
            end
        end
    end

    assign mac_valid_out = mdl_vo | force_vo;
    assign mac_f         = mdl_f;
    assign mac_overflow  = mdl_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Row r = sum_c W[r][c]*V[c] + bias[r]; overflow if any running sum
    // leaves the signed 16-bit range.
    function automatic void ref_row(input int r, output logic [15:0] d, output logic o);
        int s;
        s = 0;
        o = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s = s + int'($signed(words[r*3+c])) * int'($signed(words[9+c]));
            if (oor(s)) o = 1'b1;
        end
        s = s + int'(words[12+r]);
        if (oor(s)) o = 1'b1;
        d = s[15:0];
    endfunction

    task automatic set_pattern(input int kind);
        for (int i = 0; i < 15; i++) begin
            case (kind)
                1: words[i] = (i < 9) ? ((i % 4 == 0) ? 8'd1 : 8'd0) : (i < 12) ? 8'(i - 8) : 8'd0;
                2: words[i] = (i < 9) ? 8'd2 : (i < 12) ? 8'd3 : (i == 12) ? 8'd5 : (i == 13) ? 8'd0 : 8'd10;
                3: words[i] = (i < 12) ? 8'd127 : 8'd0;
                default: words[i] = 8'($urandom);
            endcase
        end
        for (int r = 0; r < 3; r++) ref_row(r, exp_d[r], exp_o[r]);
    endtask

    task automatic load_words(input bit gaps);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        while (idx < 15 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = words[idx];
                if (s_ready) idx++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("load_count", idx, 15);
    endtask

    task automatic collect(input bit stall);
        int guard;
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (m_valid !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("m_valid", m_valid, 1);
            check("m_data", m_data, exp_d[k]);
            check("m_ovf", m_ovf, exp_o[k]);
            if (stall) begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold", {m_valid, m_ovf, m_data}, {1'b1, exp_o[k], exp_d[k]});
                end
            end
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
        check("m_valid_drop", m_valid, 0);
        check("idle_after", {busy, s_ready}, 2'b01);
    endtask

    task automatic run_case(input bit gaps, input bit stall);
        int cnt;
        int guard;
        load_words(gaps);
        cnt   = 0;
        guard = 0;
        while (guard < 40 && !(cnt > 0 && !mac_valid)) begin
            if (mac_valid) begin
                if (cnt < 9)
                    check("operands", {8'h0, mac_a, mac_b, mac_x},
                          {8'h0, words[cnt], words[9 + cnt % 3], words[12 + cnt / 3]});
                cnt++;
            end
            @(negedge clk);
            guard++;
        end
        check("strobe_count", cnt, 9);
        collect(stall);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_mac", {mac_valid, mac_a, mac_b, mac_x}, 0);
        check("rst_m", {m_valid, m_ovf, m_data}, 0);
        check("rst_flags", {busy, err}, 0);
        reset = 1'b1;
        #1 check("idle_ready", {busy, s_ready}, 2'b01);

        set_pattern(1); run_case(1'b0, 1'b0);
        set_pattern(2); run_case(1'b0, 1'b0);
        set_pattern(3); run_case(1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            set_pattern(4); run_case(1'b0, 1'b0);
        end

        set_pattern(4);
        run_case(1'b0, 1'b0);
        run_case(1'b1, 1'b1);

        set_pattern(4);
        load_words(1'b0);
        repeat (3) @(negedge clk);
        check("s5_stream4", {busy, mac_valid}, 2'b11);
        reset = 1'b0;
        #1;
        check("s5_rst_mac", {mac_valid, mac_a, mac_b, mac_x}, 0);
        check("s5_rst_misc", {busy, s_ready, m_valid, m_ovf, err, m_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("s5_release", {busy, s_ready}, 2'b01);
        set_pattern(1); run_case(1'b0, 1'b0);

        check("s6_err_clear", err, 0);
        @(negedge clk);
        force_vo = 1'b1;
        @(negedge clk);
        force_vo = 1'b0;
        check("s6_err_set", {busy, err}, 2'b01);
        repeat (3) @(negedge clk);
        check("s6_err_sticky", err, 1);
        set_pattern(4); run_case(1'b0, 1'b0);
        check("s6_err_after", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
